capture_sequencer: RTL and testbench
====================================

# capture_sequencer

Sequences an RF capture session on the ADC sample stream and feeds the USB-bound sample FIFO. Sits between the ADC data register stage and the FIFO write port. Starts and stops capture on the host collect request, selects test-pattern or live ADC data, and packs each 10-bit sample into a 16-bit FIFO word. Always terminates on a whole transfer block and flags FIFO overflow as a sticky error.

## Interface
Parameters:
- BLOCK_WORDS, 8192: FIFO words per host transfer block. Power of two, 4..65536.
- SYNC_CYCLES, 2: samples discarded after start to flush the ADC register pipeline. Range 1..15.

Ports:
- clock  in  1  sample clock; all logic on rising edge.
- nReset  in  1  reset, asynchronous, active-low.
- collectRequest  in  1  host capture enable, already synchronous to clock.
- testModeRequest  in  1  host request for the test counter pattern; sampled only at capture start.
- adcData  in  10  registered sample from the ADC read stage.
- fifoFull  in  1  FIFO cannot accept a write this cycle.
- nTestmode  out  1  to the ADC read stage; 0 = test pattern, 1 = live ADC.
- fifoWrite  out  1  FIFO write strobe, one word per asserted cycle.
- fifoData  out  16  FIFO write word.
- capturing  out  1  high in SYNC, CAPTURE and FINISH.
- bufferOverflow  out  1  sticky overflow error.
- blockCount  out  16  completed blocks in the current session; wraps modulo 2^16.

## Operation
- States: IDLE, SYNC, CAPTURE, FINISH, OVERFLOW.
- IDLE:
  - fifoWrite=0.
  - When collectRequest=1, go to SYNC: latch nTestmode=!testModeRequest, clear bufferOverflow, blockCount, wordCount and syncCount.
- SYNC:
  - fifoWrite=0; syncCount increments each cycle.
  - After SYNC_CYCLES cycles, go to CAPTURE.
  - If collectRequest drops, go to IDLE; nothing is written.
- CAPTURE:
  - Each cycle: fifoWrite=1, fifoData={tag,adcData}.
  - wordCount increments. At BLOCK_WORDS-1 it wraps to 0 and blockCount increments.
  - collectRequest=0 goes to FINISH.
- FINISH:
  - Keeps writing live samples until the word at wordCount=BLOCK_WORDS-1 is written, then goes to IDLE.
  - If collectRequest drops exactly on the last word of a block, the write completes and the state goes directly to IDLE.
- OVERFLOW, entered from CAPTURE or FINISH whenever fifoFull=1:
  - No write occurs that cycle. bufferOverflow=1, fifoWrite=0.
  - Stays until collectRequest=0, then goes to IDLE. bufferOverflow holds until the next session start or reset.
- Priority: fifoFull over collectRequest drop over block wrap.
- nTestmode changes only on the IDLE→SYNC transition; a mid-session testModeRequest change is ignored.
- Arithmetic: wordCount is log2(BLOCK_WORDS) bits; blockCount is 16 bits and wraps 0xFFFF→0 without error.

## Timing
- All outputs are registered.
- Reset values: nTestmode=1, fifoWrite=0, fifoData=0, capturing=0, bufferOverflow=0, blockCount=0; state=IDLE.
- Reset mid-session aborts immediately; a partial block is not completed.
- Start latency: the first fifoWrite occurs SYNC_CYCLES+1 cycles after the first cycle collectRequest is seen high.
- Data latency: adcData to fifoData is 1 cycle; fifoWrite is coincident with its fifoData.
- The fifoFull check uses the current-cycle value; a full FIFO never receives a write.
- capturing falls in the same cycle the state returns to IDLE.

## Configuration
- CAPTURE_TAG_EN defined: fifoData[15:10]=blockCount[5:0], so the host can detect dropped blocks.
- CAPTURE_TAG_EN undefined: fifoData[15:10]=6'b0 and fifoData is the zero-extended sample. blockCount is still output.

## Test plan
- Basic capture, BLOCK_WORDS=8, SYNC_CYCLES=2, testModeRequest=0: raise collectRequest and hold for 20 cycles with adcData ramping → first write 3 cycles after the rise; exactly 24 words written; blockCount ends at 3; capturing then returns to 0.
- Test mode: start with testModeRequest=1, then toggle it mid-capture → nTestmode=0 for the whole session and returns to 1 only at the next start with the request low.
- Overflow: pulse fifoFull=1 for 1 cycle at word 5 → no write that cycle; bufferOverflow=1; state holds in OVERFLOW with fifoWrite=0 until collectRequest=0. The next start clears bufferOverflow.
- Short start: collectRequest high for 1 cycle only → no fifoWrite, blockCount=0, back to IDLE.
- Wrap and tag, BLOCK_WORDS=4 with CAPTURE_TAG_EN: run 70 blocks → fifoData[15:10] cycles 0..63 then 0..5; blockCount=70. Without CAPTURE_TAG_EN, fifoData[15:10] is always 0.
- Reset: assert nReset during FINISH → all outputs at reset values immediately; no further writes.

Source files
------------

// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Sequences an RF capture session on the ADC sample stream and feeds the
//   USB-bound sample FIFO. A session starts on collectRequest, discards
//   SYNC_CYCLES samples to flush the ADC register pipeline, then writes one
//   16-bit word per cycle. Once collectRequest drops, capture always ends on a
//   whole block. A full FIFO aborts the session into a sticky overflow state.
//
//   Build option: define CAPTURE_TAG_EN to place blockCount[5:0] in
//   fifoData[15:10] so the host can spot dropped blocks; otherwise the upper
//   six bits are zero.
//
// Ports
//   clock            sample clock, rising edge
//   nReset           asynchronous active-low reset
//   collectRequest   host capture enable (synchronous to clock)
//   testModeRequest  host test-pattern request, sampled at session start only
//   adcData[9:0]     registered ADC sample
//   fifoFull         FIFO cannot accept a write this cycle
//   nTestmode        0 = test pattern, 1 = live ADC
//   fifoWrite        FIFO write strobe
//   fifoData[15:0]   FIFO write word {tag, sample}
//   capturing        high in SYNC, CAPTURE and FINISH
//   bufferOverflow   sticky overflow error, cleared at next session start
//   blockCount[15:0] blocks completed in this session, wraps modulo 2^16
//
// States
//   IDLE     | waiting for collectRequest
//   SYNC     | discarding pipeline samples after start
//   CAPTURE  | writing one word per cycle while collectRequest is high
//   FINISH   | request dropped; writing until the block is complete
//   OVERFLOW | FIFO was full; waiting for collectRequest to drop

module capture_sequencer #(
  parameter int BLOCK_WORDS = 8192,
  parameter int SYNC_CYCLES = 2
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        collectRequest,
  input  logic        testModeRequest,
  input  logic [9:0]  adcData,
  input  logic        fifoFull,
  output logic        nTestmode,
  output logic        fifoWrite,
  output logic [15:0] fifoData,
  output logic        capturing,
  output logic        bufferOverflow,
  output logic [15:0] blockCount
);

  localparam int WW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [WW-1:0] LAST_WORD = WW'(BLOCK_WORDS - 1);
  localparam logic [3:0]    SYNC_LAST = 4'(SYNC_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYNC     = 3'd1,
    CAPTURE  = 3'd2,
    FINISH   = 3'd3,
    OVERFLOW = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] word_count_q, word_count_d;
  logic [3:0]    sync_count_q, sync_count_d;
  logic          n_testmode_q, n_testmode_d;
  logic          fifo_write_q, fifo_write_d;
  logic [15:0]   fifo_data_q, fifo_data_d;
  logic          capturing_q, capturing_d;
  logic          buffer_overflow_q, buffer_overflow_d;
  logic [15:0]   block_count_q, block_count_d;
  logic [5:0]    tag;
  logic          last_word;

`ifdef CAPTURE_TAG_EN
  assign tag = block_count_q[5:0];
`else
  assign tag = 6'd0;
`endif

  assign last_word = (word_count_q == LAST_WORD);

  always_comb begin
    state_d           = state_q;
    word_count_d      = word_count_q;
    sync_count_d      = sync_count_q;
    n_testmode_d      = n_testmode_q;
    fifo_write_d      = 1'b0;
    fifo_data_d       = fifo_data_q;
    buffer_overflow_d = buffer_overflow_q;
    block_count_d     = block_count_q;

    case (state_q)
      IDLE: begin
        if (collectRequest) begin
          state_d           = SYNC;
          n_testmode_d      = ~testModeRequest;
          buffer_overflow_d = 1'b0;
          block_count_d     = 16'd0;
          word_count_d      = '0;
          sync_count_d      = 4'd0;
        end
      end
      SYNC: begin
        sync_count_d = sync_count_q + 4'd1;
        if (!collectRequest) begin
          state_d = IDLE;
        end else if (sync_count_q == SYNC_LAST) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE, FINISH: begin
        // A full FIFO wins over both the request drop and the block wrap.
        if (fifoFull) begin
          state_d           = OVERFLOW;
          buffer_overflow_d = 1'b1;
        end else begin
          fifo_write_d = 1'b1;
          fifo_data_d  = {tag, adcData};
          if (last_word) begin
            word_count_d  = '0;
            block_count_d = block_count_q + 16'd1;
          end else begin
            word_count_d = word_count_q + WW'(1);
          end
          // Once stopping, the session ends only after the last word of a block.
          if ((state_q == FINISH) || !collectRequest) begin
            state_d = last_word ? IDLE : FINISH;
          end
        end
      end
      OVERFLOW: begin
        if (!collectRequest) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered from the next state so capturing tracks the state exactly.
    capturing_d = (state_d == SYNC) || (state_d == CAPTURE) || (state_d == FINISH);
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q           <= IDLE;
      word_count_q      <= '0;
      sync_count_q      <= 4'd0;
      n_testmode_q      <= 1'b1;
      fifo_write_q      <= 1'b0;
      fifo_data_q       <= 16'd0;
      capturing_q       <= 1'b0;
      buffer_overflow_q <= 1'b0;
      block_count_q     <= 16'd0;
    end else begin
      state_q           <= state_d;
      word_count_q      <= word_count_d;
      sync_count_q      <= sync_count_d;
      n_testmode_q      <= n_testmode_d;
      fifo_write_q      <= fifo_write_d;
      fifo_data_q       <= fifo_data_d;
      capturing_q       <= capturing_d;
      buffer_overflow_q <= buffer_overflow_d;
      block_count_q     <= block_count_d;
    end
  end

  assign nTestmode      = n_testmode_q;
  assign fifoWrite      = fifo_write_q;
  assign fifoData       = fifo_data_q;
  assign capturing      = capturing_q;
  assign bufferOverflow = buffer_overflow_q;
  assign blockCount     = block_count_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Testbench for capture_sequencer (BLOCK_WORDS=8, SYNC_CYCLES=2).
// A session-level reference model predicts every output after each clock.

module tb_capture_sequencer;

  localparam int BW = 8;
  localparam int SC = 2;

  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        collectRequest = 1'b0;
  logic        testModeRequest = 1'b0;
  logic [9:0]  adcData = 10'd0;
  logic        fifoFull = 1'b0;
  logic        nTestmode;
  logic        fifoWrite;
  logic [15:0] fifoData;
  logic        capturing;
  logic        bufferOverflow;
  logic [15:0] blockCount;

  int checks = 0;
  int errors = 0;

  // Reference model: session described by counters rather than states.
  bit          m_active;     // session running (pipeline flush or writing)
  int          m_sync_left;  // flush samples still to discard
  bit          m_draining;   // request dropped, completing the block
  bit          m_ovf_hold;   // aborted on full FIFO, waiting for request drop
  bit          m_ovf;
  bit          m_ntest;
  bit          m_write;
  int          m_words;      // words written this session
  logic [15:0] m_data;
  int          writes_seen;

  capture_sequencer #(.BLOCK_WORDS(BW), .SYNC_CYCLES(SC)) dut (
    .clock          (clock),
    .nReset         (nReset),
    .collectRequest (collectRequest),
    .testModeRequest(testModeRequest),
    .adcData        (adcData),
    .fifoFull       (fifoFull),
    .nTestmode      (nTestmode),
    .fifoWrite      (fifoWrite),
    .fifoData       (fifoData),
    .capturing      (capturing),
    .bufferOverflow (bufferOverflow),
    .blockCount     (blockCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task model_reset();
    m_active = 0; m_sync_left = 0; m_draining = 0; m_ovf_hold = 0;
    m_ovf = 0; m_ntest = 1; m_write = 0; m_words = 0; m_data = 16'd0;
  endtask

  task model_step();
    m_write = 0;
    if (!nReset) begin
      model_reset();
    end else if (m_ovf_hold) begin
      if (!collectRequest) m_ovf_hold = 0;
    end else if (!m_active) begin
      if (collectRequest) begin
        m_active = 1; m_sync_left = SC; m_draining = 0;
        m_ntest = !testModeRequest; m_ovf = 0; m_words = 0;
      end
    end else if (m_sync_left > 0) begin
      if (!collectRequest) m_active = 0;
      else m_sync_left--;
    end else if (fifoFull) begin
      m_active = 0; m_draining = 0; m_ovf_hold = 1; m_ovf = 1;
    end else begin
      m_write = 1;
`ifdef CAPTURE_TAG_EN
      m_data = {6'((m_words / BW) % 64), adcData};
`else
      m_data = {6'd0, adcData};
`endif
      m_words++;
      if (!collectRequest) m_draining = 1;
      if (m_draining && (m_words % BW == 0)) begin
        m_active = 0; m_draining = 0;
      end
    end
  endtask

  task check_outputs();
    chk("nTestmode", nTestmode, m_ntest);
    chk("fifoWrite", fifoWrite, m_write);
    chk("fifoData", fifoData, m_data);
    chk("capturing", capturing, m_active);
    chk("bufferOverflow", bufferOverflow, m_ovf);
    chk("blockCount", blockCount, 16'((m_words / BW) % 65536));
  endtask

  task tick();
    @(posedge clock);
    #1;
    model_step();
    check_outputs();
    if (fifoWrite === 1'b1) writes_seen++;
  endtask

  task drain(input int budget);
    for (int n = 0; n < budget && (m_active || m_ovf_hold); n++) begin
      adcData = 10'($urandom_range(0, 1023));
      tick();
    end
    chk("drain_done", {31'd0, capturing}, 32'd0);
  endtask

  initial begin
    int first;
    model_reset();

    // Reset values
    #12;
    check_outputs();
    nReset = 1'b1;
    repeat (2) tick();

    // Basic capture: 20 cycles of request -> 24 words, 3 blocks
    writes_seen = 0;
    first = -1;
    collectRequest = 1'b1;
    for (int i = 0; i < 20; i++) begin
      adcData = 10'(i * 3 + 1);
      tick();
      if (first < 0 && fifoWrite === 1'b1) first = i;
    end
    collectRequest = 1'b0;
    for (int i = 20; i < 60 && m_active; i++) begin
      adcData = 10'(i * 3 + 1);
      tick();
    end
    chk("basic_latency", first, SC + 1);
    chk("basic_words", writes_seen, 24);
    chk("basic_blocks", blockCount, 3);
    chk("basic_capturing", {31'd0, capturing}, 0);

    // Test mode latched at start, mid-session toggles ignored
    testModeRequest = 1'b1;
    collectRequest = 1'b1;
    tick();
    testModeRequest = 1'b0;
    repeat (5) tick();
    testModeRequest = 1'b1;
    repeat (3) tick();
    chk("tm_session", {31'd0, nTestmode}, 0);
    collectRequest = 1'b0;
    testModeRequest = 1'b0;
    drain(40);
    chk("tm_held_idle", {31'd0, nTestmode}, 0);
    collectRequest = 1'b1;
    tick();
    chk("tm_restart", {31'd0, nTestmode}, 1);
    collectRequest = 1'b0;
    drain(40);

    // Overflow at word 5
    collectRequest = 1'b1;
    for (int n = 0; n < 40 && !(m_active && m_words == 5); n++) begin
      adcData = 10'($urandom_range(0, 1023));
      tick();
    end
    fifoFull = 1'b1;
    tick();
    fifoFull = 1'b0;
    chk("ovf_flag", {31'd0, bufferOverflow}, 1);
    chk("ovf_nowrite", {31'd0, fifoWrite}, 0);
    repeat (6) tick();
    chk("ovf_hold_flag", {31'd0, bufferOverflow}, 1);
    chk("ovf_hold_capt", {31'd0, capturing}, 0);
    collectRequest = 1'b0;
    tick();
    collectRequest = 1'b1;
    tick();
    chk("ovf_cleared", {31'd0, bufferOverflow}, 0);
    collectRequest = 1'b0;
    drain(40);

    // Short start: one cycle of request
    writes_seen = 0;
    collectRequest = 1'b1;
    tick();
    collectRequest = 1'b0;
    repeat (6) tick();
    chk("short_writes", writes_seen, 0);
    chk("short_blocks", blockCount, 0);

    // Wrap and tag: 70 blocks
    collectRequest = 1'b1;
    for (int n = 0; n < 70 * BW + 50 && m_words < 69 * BW + 1; n++) begin
      adcData = 10'($urandom_range(0, 1023));
      tick();
    end
    collectRequest = 1'b0;
    drain(2 * BW + 10);
    chk("wrap_blocks", blockCount, 70);

    // Randomised sessions
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) collectRequest = ~collectRequest;
      fifoFull = ($urandom_range(0, 149) == 0);
      testModeRequest = 1'($urandom_range(0, 1));
      adcData = 10'($urandom_range(0, 1023));
      tick();
    end
    fifoFull = 1'b0;
    collectRequest = 1'b0;
    drain(40);

    // Reset during FINISH
    writes_seen = 0;
    collectRequest = 1'b1;
    for (int n = 0; n < 40 && !(m_active && m_words == 3); n++) begin
      adcData = 10'($urandom_range(0, 1023));
      tick();
    end
    collectRequest = 1'b0;
    repeat (2) tick();
    chk("rst_in_finish", {31'd0, m_draining}, 1);
    nReset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    writes_seen = 0;
    repeat (3) tick();
    nReset = 1'b1;
    repeat (BW + 2) tick();
    chk("rst_no_writes", writes_seen, 0);
    chk("rst_blocks", blockCount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
